// File: rtl/core_boot_loader_pkg.sv
// Shared boot/network definitions: packet and store structs, boot FSM states,
// fixed packet constants and small helpers used by the boot loader.
package core_boot_loader_pkg;

    typedef enum logic [2:0] {
        NET_OP_NULL  = 3'd0,
        NET_OP_INSTR = 3'd1,
        NET_OP_REG   = 3'd2,
        NET_OP_PC    = 3'd3,
        NET_OP_BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [9:0]  id;
        net_op_e     net_op;
        logic [4:0]  reserved;
        logic [31:0] net_data;
        logic [9:0]  net_addr;
    } net_packet_s;

    typedef struct packed {
        logic        valid;
        logic        yumi;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
    } mem_in_s;

    typedef enum logic [2:0] {
        BOOT_IDLE,
        BOOT_DATA,
        BOOT_HANDOFF,
        BOOT_INSTR,
        BOOT_REG,
        BOOT_BAR,
        BOOT_PC,
        BOOT_DONE
    } boot_state_e;

    localparam logic [9:0]  BOOT_NET_ID    = 10'd1;
    localparam logic [9:0]  BAR_NET_ADDR   = 10'd24;
    localparam logic [31:0] NULL_IDLE_DATA = 32'hFFFF_FFFE;

    // A single-entry ROM still needs a one-bit address port.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic net_packet_s make_packet(input net_op_e op,
                                                input logic [31:0] data,
                                                input logic [9:0] addr);
        net_packet_s p;
        p.id       = BOOT_NET_ID;
        p.net_op   = op;
        p.reserved = '0;
        p.net_data = data;
        p.net_addr = addr;
        return p;
    endfunction

endpackage

// File: rtl/core_boot_loader_boot_word_fetcher.sv
// Walks a synchronous ROM from address 0 to WORDS-1 once per start pulse and
// flags, one cycle later, which word the ROM is presenting and whether it is the last.
module core_boot_loader_boot_word_fetcher
    import core_boot_loader_pkg::*;
#(
    parameter int WORDS = 1024,
    localparam int AW = addr_width(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] idx,
    output logic          last,
    output logic          data_valid
);

    if (WORDS < 1) begin : g_bad_words
        $error("boot_word_fetcher: WORDS must be at least 1");
    end

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    logic [AW-1:0] cnt_reg;
    logic [AW-1:0] idx_reg;
    logic          active_reg;
    logic          valid_reg;
    logic          last_reg;

    // valid/idx/last trail the address by one cycle to line up with ROM data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg    <= '0;
            idx_reg    <= '0;
            active_reg <= 1'b0;
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
        end else begin
            valid_reg <= active_reg;
            idx_reg   <= cnt_reg;
            last_reg  <= active_reg && (cnt_reg == LAST_ADDR);
            if (start) begin
                cnt_reg    <= '0;
                active_reg <= 1'b1;
            end else if (active_reg) begin
                if (cnt_reg == LAST_ADDR) begin
                    active_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign addr       = cnt_reg;
    assign idx        = idx_reg;
    assign last       = last_reg;
    assign data_valid = valid_reg;

endmodule

// File: rtl/core_boot_loader.sv
// Boot sequencer: data_mem init stores, then INSTR/REG/BAR/PC packets, then NULL.
// Define BOOT_CHECKSUM_EN to build the running checksum of all emitted words.
module core_boot_loader
    import core_boot_loader_pkg::*;
#(
    parameter int          DATA_WORDS  = 1024,
    parameter int          INSTR_WORDS = 1024,
    parameter int          REG_WORDS   = 64,
    parameter logic [31:0] BAR_MASK    = 32'h2,
    parameter logic [31:0] START_PC    = 32'h5,
    localparam int DAW = addr_width(DATA_WORDS),
    localparam int IAW = addr_width(INSTR_WORDS),
    localparam int RAW = addr_width(REG_WORDS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    output logic [DAW-1:0]              data_rom_addr_o,
    input  logic [31:0]                 data_rom_i,
    output logic [IAW-1:0]              instr_rom_addr_o,
    input  logic [15:0]                 instr_rom_i,
    output logic [RAW-1:0]              reg_rom_addr_o,
    input  logic [39:0]                 reg_rom_i,
    output logic [$bits(mem_in_s)-1:0]  mem_in_flat_o,
    output logic [31:0]                 mem_addr_o,
    output logic                        mem_sel_o,
    output logic [$bits(net_packet_s)-1:0] net_packet_flat_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [31:0]                 checksum_o
);

    boot_state_e state_reg, state_next;
    mem_in_s     mem_in_reg, mem_in_next;
    net_packet_s packet_reg, packet_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic        mem_sel_reg, mem_sel_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;

    logic           data_start, instr_start, reg_start;
    logic [DAW-1:0] data_idx;
    logic [IAW-1:0] instr_idx;
    logic [RAW-1:0] reg_idx_unused;
    logic           data_last, instr_last, reg_last;
    logic           data_valid, instr_valid, reg_valid;
    logic           reg_rom_unused;

    assign reg_rom_unused = ^{reg_rom_i[39:38], reg_idx_unused};

    core_boot_loader_boot_word_fetcher #(.WORDS(DATA_WORDS)) u_data_fetcher (
        .clk(clk), .reset(reset), .start(data_start), .addr(data_rom_addr_o),
        .idx(data_idx), .last(data_last), .data_valid(data_valid)
    );

    core_boot_loader_boot_word_fetcher #(.WORDS(INSTR_WORDS)) u_instr_fetcher (
        .clk(clk), .reset(reset), .start(instr_start), .addr(instr_rom_addr_o),
        .idx(instr_idx), .last(instr_last), .data_valid(instr_valid)
    );

    core_boot_loader_boot_word_fetcher #(.WORDS(REG_WORDS)) u_reg_fetcher (
        .clk(clk), .reset(reset), .start(reg_start), .addr(reg_rom_addr_o),
        .idx(reg_idx_unused), .last(reg_last), .data_valid(reg_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= BOOT_IDLE;
            mem_in_reg   <= '0;
            mem_addr_reg <= '0;
            mem_sel_reg  <= 1'b0;
            packet_reg   <= make_packet(NET_OP_NULL, '0, '0);
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mem_in_reg   <= mem_in_next;
            mem_addr_reg <= mem_addr_next;
            mem_sel_reg  <= mem_sel_next;
            packet_reg   <= packet_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mem_in_next   = '0;
        mem_addr_next = '0;
        packet_next   = make_packet(NET_OP_NULL, '0, '0);
        data_start    = 1'b0;
        instr_start   = 1'b0;
        reg_start     = 1'b0;
        // Memory is only handed to the core once the handoff cycle has drained.
        mem_sel_next  = !(state_reg inside {BOOT_IDLE, BOOT_DATA, BOOT_HANDOFF});
        busy_next     = !(state_reg inside {BOOT_IDLE, BOOT_DONE});
        done_next     = (state_reg == BOOT_DONE);

        case (state_reg)
            BOOT_IDLE: begin
                if (start_i) begin
                    data_start = 1'b1;
                    state_next = BOOT_DATA;
                end
            end
            BOOT_DATA: begin
                if (data_valid) begin
                    mem_in_next.valid      = 1'b1;
                    mem_in_next.yumi       = 1'b1;
                    mem_in_next.wen        = 1'b1;
                    mem_in_next.write_data = data_rom_i;
                    mem_addr_next          = 32'(data_idx) << 2;
                    if (data_last) state_next = BOOT_HANDOFF;
                end
            end
            BOOT_HANDOFF: begin
                instr_start = 1'b1;
                state_next  = BOOT_INSTR;
            end
            BOOT_INSTR: begin
                if (instr_valid) begin
                    packet_next = make_packet(NET_OP_INSTR, {16'b0, instr_rom_i}, 10'(instr_idx));
                    if (instr_last) begin
                        reg_start  = 1'b1;
                        state_next = BOOT_REG;
                    end
                end
            end
            BOOT_REG: begin
                if (reg_valid) begin
                    packet_next = make_packet(NET_OP_REG, reg_rom_i[31:0], {4'b0, reg_rom_i[37:32]});
                    if (reg_last) state_next = BOOT_BAR;
                end
            end
            BOOT_BAR: begin
                packet_next = make_packet(NET_OP_BAR, BAR_MASK, BAR_NET_ADDR);
                state_next  = BOOT_PC;
            end
            BOOT_PC: begin
                packet_next = make_packet(NET_OP_PC, START_PC, '0);
                state_next  = BOOT_DONE;
            end
            BOOT_DONE: begin
                packet_next = make_packet(NET_OP_NULL, NULL_IDLE_DATA, BAR_NET_ADDR);
            end
            default: state_next = BOOT_IDLE;
        endcase
    end

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] checksum_reg;
    logic [31:0] checksum_add;

    always_comb begin
        checksum_add = '0;
        if (state_reg == BOOT_DATA && data_valid)   checksum_add = data_rom_i;
        if (state_reg == BOOT_INSTR && instr_valid) checksum_add = {16'b0, instr_rom_i};
        if (state_reg == BOOT_REG && reg_valid)     checksum_add = reg_rom_i[31:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_reg <= '0;
        end else if (state_reg == BOOT_IDLE && start_i) begin
            checksum_reg <= '0;
        end else begin
            checksum_reg <= checksum_reg + checksum_add;
        end
    end

    assign checksum_o = checksum_reg;
`else
    assign checksum_o = '0;
`endif

    assign mem_in_flat_o     = mem_in_reg;
    assign mem_addr_o        = mem_addr_reg;
    assign mem_sel_o         = mem_sel_reg;
    assign net_packet_flat_o = packet_reg;
    assign busy_o            = busy_reg;
    assign done_o            = done_reg;

endmodule

// File: tb/tb_core_boot_loader.sv
// Self-checking bench for core_boot_loader with D=4, I=4, R=2: expected outputs
// are derived per cycle from the boot timeline formulas and the bench's ROM images.
module tb_core_boot_loader;
    import core_boot_loader_pkg::*;

    localparam int D = 4;
    localparam int I = 4;
    localparam int R = 2;
    localparam int T_DONE = 7 + D + I + R;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  data_rom_addr_o;
    logic [31:0] data_rom_i;
    logic [1:0]  instr_rom_addr_o;
    logic [15:0] instr_rom_i;
    logic [0:0]  reg_rom_addr_o;
    logic [39:0] reg_rom_i;
    logic [$bits(mem_in_s)-1:0]     mem_in_flat_o;
    logic [31:0] mem_addr_o;
    logic        mem_sel_o;
    logic [$bits(net_packet_s)-1:0] net_packet_flat_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] checksum_o;

    logic [31:0] drom [D];
    logic [15:0] irom [I];
    logic [39:0] rrom [R];

    int checks = 0;
    int failures = 0;

    mem_in_s     mem_obs;
    net_packet_s pkt_obs;
    assign mem_obs = mem_in_s'(mem_in_flat_o);
    assign pkt_obs = net_packet_s'(net_packet_flat_o);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_rom_i  <= drom[data_rom_addr_o];
        instr_rom_i <= irom[instr_rom_addr_o];
        reg_rom_i   <= rrom[reg_rom_addr_o];
    end

    core_boot_loader #(
        .DATA_WORDS(D), .INSTR_WORDS(I), .REG_WORDS(R),
        .BAR_MASK(32'h2), .START_PC(32'h5)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .data_rom_addr_o(data_rom_addr_o), .data_rom_i(data_rom_i),
        .instr_rom_addr_o(instr_rom_addr_o), .instr_rom_i(instr_rom_i),
        .reg_rom_addr_o(reg_rom_addr_o), .reg_rom_i(reg_rom_i),
        .mem_in_flat_o(mem_in_flat_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .net_packet_flat_o(net_packet_flat_o), .busy_o(busy_o), .done_o(done_o),
        .checksum_o(checksum_o)
    );

    // Expected store n cycles after the start edge: word n-2 during the data phase.
    function automatic mem_in_s exp_store(input int n);
        mem_in_s s;
        s = '0;
        if (n >= 2 && n < 2 + D) begin
            s.valid = 1'b1; s.yumi = 1'b1; s.wen = 1'b1;
            s.write_data = drom[n-2];
        end
        return s;
    endfunction

    function automatic net_packet_s exp_packet(input int n);
        net_packet_s p;
        int j;
        p.id = 10'd1; p.reserved = '0;
        p.net_op = NET_OP_NULL; p.net_data = '0; p.net_addr = '0;
        if (n >= 4 + D && n < 4 + D + I) begin
            j = n - 4 - D;
            p.net_op = NET_OP_INSTR; p.net_data = {16'b0, irom[j]}; p.net_addr = 10'(j);
        end else if (n >= 5 + D + I && n < 5 + D + I + R) begin
            j = n - 5 - D - I;
            p.net_op = NET_OP_REG; p.net_data = rrom[j][31:0]; p.net_addr = {4'b0, rrom[j][37:32]};
        end else if (n == 5 + D + I + R) begin
            p.net_op = NET_OP_BAR; p.net_data = 32'h2; p.net_addr = 10'd24;
        end else if (n == 6 + D + I + R) begin
            p.net_op = NET_OP_PC; p.net_data = 32'h5; p.net_addr = 10'd0;
        end else if (n >= T_DONE) begin
            p.net_op = NET_OP_NULL; p.net_data = 32'hFFFF_FFFE; p.net_addr = 10'd24;
        end
        return p;
    endfunction

    function automatic logic [31:0] exp_checksum();
        logic [31:0] sum;
        sum = '0;
`ifdef BOOT_CHECKSUM_EN
        for (int k = 0; k < D; k++) sum += drom[k];
        for (int k = 0; k < I; k++) sum += {16'b0, irom[k]};
        for (int k = 0; k < R; k++) sum += rrom[k][31:0];
`endif
        return sum;
    endfunction

    task automatic load_fixed_roms();
        drom[0] = 32'd11; drom[1] = 32'd22; drom[2] = 32'd33; drom[3] = 32'd44;
        irom[0] = 16'd1;  irom[1] = 16'd2;  irom[2] = 16'd3;  irom[3] = 16'd4;
        rrom[0] = {2'b0, 6'd1, 32'hA};
        rrom[1] = {2'b0, 6'd2, 32'hB};
    endtask

    task automatic load_random_roms();
        for (int k = 0; k < D; k++) drom[k] = $urandom();
        for (int k = 0; k < I; k++) irom[k] = 16'($urandom());
        for (int k = 0; k < R; k++) rrom[k] = {2'b0, 6'($urandom()), 32'($urandom())};
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        net_packet_s p;
        apply_reset();
        p = make_packet(NET_OP_NULL, '0, '0);
        checks++; if (mem_obs !== '0) begin failures++; $display("FAIL reset_mem_in: got %h want 0", mem_obs); end
        checks++; if (mem_addr_o !== 32'd0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
        checks++; if (mem_sel_o !== 1'b0) begin failures++; $display("FAIL reset_mem_sel: got %b want 0", mem_sel_o); end
        checks++; if (pkt_obs !== p) begin failures++; $display("FAIL reset_packet: got %h want %h", pkt_obs, p); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (checksum_o !== 32'd0) begin failures++; $display("FAIL reset_checksum: got %h want 0", checksum_o); end
        $display("reset: outputs checked at reset values");
    endtask

    // One boot from IDLE. reset_at/start_at (0 = never) inject a reset or an
    // extra start pulse sampled at edge S+n; cycles sets how far past S to check.
    task automatic test_boot(input string tag, input int reset_at, input int start_at, input int cycles);
        mem_in_s     es;
        net_packet_s ep;
        int          idle_wait;
        idle_wait = $urandom_range(3, 0);
        repeat (idle_wait) begin @(posedge clk); #1; end
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int n = 1; n <= cycles; n++) begin
            if (n == reset_at) reset = 1'b0;
            if (n == start_at) start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            if (n == reset_at) begin
                reset = 1'b1;
                ep = make_packet(NET_OP_NULL, '0, '0);
                checks++; if (mem_sel_o !== 1'b0) begin failures++; $display("FAIL %s abort_mem_sel: got %b want 0", tag, mem_sel_o); end
                checks++; if (pkt_obs !== ep) begin failures++; $display("FAIL %s abort_packet: got %h want %h", tag, pkt_obs, ep); end
                checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL %s abort_busy_done: got %b%b want 00", tag, busy_o, done_o); end
                checks++; if (mem_obs !== '0) begin failures++; $display("FAIL %s abort_mem_in: got %h want 0", tag, mem_obs); end
                $display("%s: reset at S+%0d, boot abandoned", tag, n);
                return;
            end
            es = exp_store(n);
            ep = exp_packet(n);
            checks++;
            if (mem_obs !== es) begin failures++; $display("FAIL %s store S+%0d: got %h want %h", tag, n, mem_obs, es); end
            if (es.valid) begin
                checks++;
                if (mem_addr_o !== 32'(4 * (n - 2))) begin
                    failures++; $display("FAIL %s store_addr S+%0d: got %h want %h", tag, n, mem_addr_o, 32'(4 * (n - 2)));
                end else begin
                    $display("%s: S+%0d store addr %0d data %h", tag, n, mem_addr_o, mem_obs.write_data);
                end
            end
            checks++;
            if (mem_sel_o !== (n >= D + 3)) begin failures++; $display("FAIL %s mem_sel S+%0d: got %b want %b", tag, n, mem_sel_o, n >= D + 3); end
            checks++;
            if (pkt_obs !== ep) begin
                failures++; $display("FAIL %s packet S+%0d: got %h want %h", tag, n, pkt_obs, ep);
            end else if (ep.net_op != NET_OP_NULL) begin
                $display("%s: S+%0d packet op %0d addr %0d data %h", tag, n, ep.net_op, pkt_obs.net_addr, pkt_obs.net_data);
            end
            checks++;
            if (busy_o !== (n < T_DONE)) begin failures++; $display("FAIL %s busy S+%0d: got %b want %b", tag, n, busy_o, n < T_DONE); end
            checks++;
            if (done_o !== (n >= T_DONE)) begin failures++; $display("FAIL %s done S+%0d: got %b want %b", tag, n, done_o, n >= T_DONE); end
            if (n >= T_DONE) begin
                checks++;
                if (checksum_o !== exp_checksum()) begin failures++; $display("FAIL %s checksum S+%0d: got %0d want %0d", tag, n, checksum_o, exp_checksum()); end
            end
        end
    endtask

    task automatic test_fixed_boot();
        apply_reset();
        load_fixed_roms();
        test_boot("fixed", 0, 0, T_DONE + 3);
    endtask

    task automatic test_random_boot();
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            load_random_roms();
            test_boot($sformatf("random%0d", r), 0, 0, T_DONE + 2);
        end
    endtask

    task automatic test_reset_mid_boot();
        apply_reset();
        load_fixed_roms();
        test_boot("midreset", 9, 0, T_DONE + 2);
        test_boot("restart", 0, 0, T_DONE + 2);
    endtask

    task automatic test_start_ignored();
        apply_reset();
        load_fixed_roms();
        test_boot("start_in_instr", 0, 9, T_DONE + 2);
        apply_reset();
        test_boot("start_in_done", 0, T_DONE + 1, T_DONE + 4);
    endtask

    initial begin
        test_reset();
        test_fixed_boot();
        test_random_boot();
        test_reset_mid_boot();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
